// File: rtl/mips_pkg.sv
// Shared MIPS core constants: opcodes, link register, link offset and byte-enable patterns.
package mips_pkg;

  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;

  localparam int unsigned REG_RA      = 31;
  localparam int unsigned LINK_OFFSET = 4;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/regfile_lane_merge.sv
// Byte-enable merge of an old and a new register word; shared by write and bypass paths.
module regfile_lane_merge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < DATA_W/8; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS register file with byte-lane writes, link port, registered read ports and busy scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module mips_regfile_sb
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic                     link_en,
  input  logic [DATA_W-1:0]        link_pc,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     any_busy
);

  localparam int unsigned LINK_REG = NUM_REGS - 1;

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
  logic [DATA_W-1:0]        wr_merged;
  logic [DATA_W-1:0]        link_val;

  regfile_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (regs_q[wr_addr]),
    .new_word (wr_data),
    .be       (wr_be),
    .merged   (wr_merged)
  );

  assign link_val = link_pc + DATA_W'(LINK_OFFSET);

  // Link is applied after the write so it wins on a collision; r0 is forced last.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) regs_d[r] = regs_q[r];
    if (wr_en) regs_d[wr_addr] = wr_merged;
    if (link_en) regs_d[LINK_REG] = link_val;
    regs_d[0] = '0;
  end

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (link_en) busy_d[LINK_REG] = 1'b0;
    if (iss_en) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Bypass reads the next-state arrays, so lane merge and link priority carry over unchanged.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    if (rd_en) begin
      for (int unsigned k = 0; k < NUM_RD; k++) begin
`ifdef REGFILE_BYPASS_EN
        rd_data_d[k*DATA_W +: DATA_W] = regs_d[rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy_d[k]                  = busy_d[rd_addr[k*ADDR_W +: ADDR_W]];
`else
        rd_data_d[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy_d[k]                  = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_busy  = rd_busy_q;
  assign any_busy = |busy_q;

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed self-checking bench for mips_regfile_sb (32x32, two read ports).
module tb_mips_regfile_sb;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        link_en;
  logic [31:0] link_pc;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        any_busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mips_regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .link_en  (link_en),
    .link_pc  (link_pc),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .any_busy (any_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0; link_en = 1'b0; iss_en = 1'b0;
    wr_be = BE_WORD;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    rd_en = 1'b1;
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    link_pc = '0; iss_addr = '0;
    idle();
    #1;
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_rd_busy", {62'h0, rd_busy}, 64'h0);
    chk("reset_any_busy", {63'h0, any_busy}, 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: r1 and r31 read zero after reset
    rd2(5'd1, 5'd31); tick(); idle();
    chk("t1_data", rd_data, 64'h0);
    chk("t1_busy", {62'h0, rd_busy}, 64'h0);
    chk("t1_any", {63'h0, any_busy}, 64'h0);

    // 2: word write then byte write
    wr(5'd5, 32'hDEADBEEF, BE_WORD); tick(); idle();
    wr(5'd5, 32'h000000AA, BE_BYTE); tick(); idle();
    rd2(5'd5, 5'd5); tick(); idle();
    chk("t2_lb_merge", rd_data, {32'hDEADBEAA, 32'hDEADBEAA});
    wr(5'd5, 32'h00001234, BE_HALF); tick(); idle();
    rd2(5'd5, 5'd0); tick(); idle();
    chk("t2_lh_merge", rd_data, {32'h0, 32'hDEAD1234});

    // rd_en low holds previous capture
    rd_addr = {5'd1, 5'd1}; tick();
    chk("hold", rd_data, {32'h0, 32'hDEAD1234});

    // 3: link beats simultaneous write to r31
    link_en = 1'b1; link_pc = 32'h00400010;
    wr(5'd31, 32'h12345678, BE_WORD); tick(); idle();
    rd2(5'd31, 5'd5); tick(); idle();
    chk("t3_link_wins", rd_data, {32'hDEAD1234, 32'h00400014});
    link_en = 1'b1; link_pc = 32'hFFFFFFFE; tick(); idle();
    rd2(5'd0, 5'd31); tick(); idle();
    chk("t3_link_wrap", rd_data, {32'h00000002, 32'h0});

    // 4: r0 ignores writes and issues
    wr(5'd0, 32'hFFFFFFFF, BE_WORD); tick(); idle();
    iss_en = 1'b1; iss_addr = 5'd0; tick(); idle();
    chk("t4_any", {63'h0, any_busy}, 64'h0);
    rd2(5'd0, 5'd0); tick(); idle();
    chk("t4_data", rd_data, 64'h0);
    chk("t4_busy", {62'h0, rd_busy}, 64'h0);

    // 5: scoreboard set / set-wins / clear
    iss_en = 1'b1; iss_addr = 5'd8; tick(); idle();
    chk("t5_set", {63'h0, any_busy}, 64'h1);
    iss_en = 1'b1; iss_addr = 5'd8; wr(5'd8, 32'h5, BE_BYTE); tick(); idle();
    chk("t5_set_wins", {63'h0, any_busy}, 64'h1);
    rd2(5'd8, 5'd7); tick(); idle();
    chk("t5_rd_busy", {62'h0, rd_busy}, 64'h1);
    chk("t5_rd_data", rd_data, {32'h0, 32'h5});
    wr(5'd8, 32'h0, 4'b0000); tick(); idle();
    chk("t5_clear", {63'h0, any_busy}, 64'h0);

    // link clears r31 busy
    iss_en = 1'b1; iss_addr = 5'd31; tick(); idle();
    chk("link_busy_set", {63'h0, any_busy}, 64'h1);
    link_en = 1'b1; link_pc = 32'h100; tick(); idle();
    chk("link_busy_clr", {63'h0, any_busy}, 64'h0);

    // 6: same-cycle write and read of r3
    wr(5'd3, 32'h22, BE_WORD); tick(); idle();
    wr(5'd3, 32'h11, BE_WORD); rd2(5'd3, 5'd3); tick(); idle();
`ifdef REGFILE_BYPASS_EN
    chk("t6_bypass", rd_data, {32'h11, 32'h11});
`else
    chk("t6_bypass", rd_data, {32'h22, 32'h22});
`endif
    wr(5'd3, 32'h00005500, 4'b0010); rd2(5'd3, 5'd0); tick(); idle();
`ifdef REGFILE_BYPASS_EN
    chk("t6_lane_bypass", rd_data, {32'h0, 32'h5511});
`else
    chk("t6_lane_bypass", rd_data, {32'h0, 32'h11});
`endif
    iss_en = 1'b1; iss_addr = 5'd3; rd2(5'd3, 5'd0); tick(); idle();
`ifdef REGFILE_BYPASS_EN
    chk("t6_busy_bypass", {62'h0, rd_busy}, 64'h1);
`else
    chk("t6_busy_bypass", {62'h0, rd_busy}, 64'h0);
`endif
    rd2(5'd3, 5'd3); tick(); idle();
    chk("t6_after", rd_data, {32'h5511, 32'h5511});
    chk("t6_busy_after", {62'h0, rd_busy}, 64'h3);

    // asynchronous reset mid-cycle, with a write pending across the edge
    wr(5'd5, 32'h99, BE_WORD);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_rd_busy", {62'h0, rd_busy}, 64'h0);
    chk("rst_any", {63'h0, any_busy}, 64'h0);
    tick(); idle();
    rst_n = 1'b1;
    rd2(5'd5, 5'd3); tick(); idle();
    chk("rst_discard", rd_data, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
